cfa_window_buffer: RTL
======================

# cfa_window_buffer

Assembles the 5x5 pixel neighbourhood consumed by the CFA interpolation kernel. It takes the column-major read stream produced by the address generator: five row samples per window column, with out-of-frame positions flagged. It aligns that stream with frame-memory read data, pads out-of-frame samples, shifts each completed column into a 5x5 window register, and pulses a window-valid strobe once per output pixel. It sits between the frame memory read port and the interpolation datapath.

## Interface
- DATA_W, 8, pixel width
- ROW_W, 11, output row index width
- COL_W, 11, output column index width
- RD_LAT, 1, frame-memory read latency in cycles, legal range 1..4
- PAD, 0, value substituted for out-of-frame samples

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- samp_valid  in  1  an address was issued to memory this cycle (generator buffer enable)
- samp_in_range  in  1  the issued address is inside the frame
- line_start  in  1  with the first sample of the first column of a line
- frame_end  in  1  with the last sample of the frame
- rdata  in  DATA_W  memory data, valid RD_LAT cycles after its address
- win_data  out  25*DATA_W  window; element (r,c) at bits [(r*5+c)*DATA_W +: DATA_W]; r=0 top, c=0 oldest/leftmost
- win_valid  out  1  one-cycle pulse: win_data is a new complete window
- win_row  out  ROW_W  output-pixel row of the current window (centre)
- win_col  out  COL_W  output-pixel column of the current window (centre)
- frame_done  out  1  one-cycle pulse coincident with the final window of a frame
- err_sync  out  1  sticky stream-framing error, cleared only by rst

## Operation
- samp_valid, samp_in_range, line_start and frame_end pass through an RD_LAT-stage delay line. All logic below uses the delayed strobes (suffix _d).
- Sample counter k (0..4) is the row within the column. On each samp_valid_d:
  - col_reg[k] <= samp_in_range_d ? rdata : PAD
  - k increments; it wraps 4->0.
- Column complete (samp_valid_d with k==4):
  - window columns 0..3 <= columns 1..4
  - column 4 <= {col_reg[0..3], current sample}
  - fill counter increments, saturating at 5.
- win_valid fires for every column completion that leaves fill at 5. That is the 5th and each later column of a line.
- win_col: 0 on the first window of a line, +1 per later window.
- line_start_d:
  - forces k to 0 for this sample and clears fill.
  - win_row becomes 0 if first_line is set, otherwise win_row+1; first_line is then cleared.
- first_line is set by rst and by frame_end_d.
- A line of COL_MAX pixels arrives as COL_MAX+4 columns and yields COL_MAX windows.
- frame_end_d on a column-complete sample: frame_done pulses together with that column's win_valid.
- Gaps in samp_valid (generator waiting on en) freeze all state. No output changes.
- No downstream backpressure. Flow control is upstream via the generator's en.

## Timing
- Reset values:
  - win_data all zero; win_valid, frame_done and err_sync 0
  - win_row 0, win_col 0, k 0, fill 0, first_line 1
  - delay line cleared
- Latency: last address of a column at cycle t -> win_valid high in cycle t+RD_LAT+1, with win_data updated in the same cycle.
- win_data holds between windows.
- line_start_d with k!=0: set err_sync; resynchronise (k=0, fill=0). The partial column is discarded.
- frame_end_d with k!=4: set err_sync. frame_done still pulses, one cycle after the sample.
- line_start_d and frame_end_d on the same sample (single-column frame): apply line_start first, then frame_end.
- rst mid-frame: all state returns to reset values within the same edge. In-flight delayed strobes are dropped.

## Structure
- Shared package cfa_pkg:
  - WIN=5
  - win_idx(r,c) function returning the bit offset
  - default PAD
- Sub-module cfa_strobe_delay: parameterised RD_LAT shift register carrying {valid, in_range, line_start, frame_end}.
- Window register, sample counter, fill counter and row/col counters live in the top module.

## Test plan
- 4x4 frame; rdata = row*16+col from a memory model (RD_LAT=1); address generator drives the inputs -> 16 win_valid pulses.
  - First window: centre 0x00, rows 0-1 and cols 0-1 are PAD.
  - win_row/win_col sweep 0..3.
  - frame_done coincides with the 16th pulse.
- Same frame with samp_valid randomly deasserted 30% of cycles -> identical window sequence; no spurious pulses.
- RD_LAT=3, PAD=0x55 -> identical sequence apart from padding value; win_valid latency is 4 cycles after the last column address.
- line_start asserted when k=2 -> err_sync=1; the next 5 columns produce the first window of the line, with win_col=0.
- rst asserted after 7 windows, then a fresh frame -> outputs return to reset values; the new frame starts at win_row=0, win_col=0 with no stale window.
- Two back-to-back frames -> win_row returns to 0 after frame_done; 32 windows total.

Source files
------------

// File: rtl/cfa_pkg.sv
// Shared definitions for the CFA window buffer: window geometry, strobe bundle
// and the window element bit-offset helper.
package cfa_pkg;

  localparam int WIN         = 5;
  localparam int PAD_DEFAULT = 0;

  typedef struct packed {
    logic valid;
    logic in_range;
    logic line_start;
    logic frame_end;
  } strobe_t;

  // Bit offset of window element (r,c); r=0 top row, c=0 oldest column.
  function automatic int win_idx(input int r, input int c, input int data_w);
    return (r * WIN + c) * data_w;
  endfunction

endpackage

// File: rtl/cfa_window_buffer_strobe_delay.sv
// Delays the generator strobes by the frame-memory read latency so that they
// line up with rdata.
module cfa_strobe_delay
  import cfa_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  strobe_t d,
  output strobe_t q
);

  strobe_t stage [RD_LAT];

  // Shifts every cycle, independent of samp_valid, to track memory latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < RD_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[RD_LAT-1];

endmodule

// File: rtl/cfa_window_buffer.sv
// 5x5 neighbourhood assembler: aligns the column-major sample stream with
// memory read data, pads out-of-frame samples and shifts columns into a window.
module cfa_window_buffer
  import cfa_pkg::*;
#(
  parameter int                DATA_W = 8,
  parameter int                ROW_W  = 11,
  parameter int                COL_W  = 11,
  parameter int                RD_LAT = 1,
  parameter logic [DATA_W-1:0] PAD    = DATA_W'(PAD_DEFAULT)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      samp_valid,
  input  logic                      samp_in_range,
  input  logic                      line_start,
  input  logic                      frame_end,
  input  logic [DATA_W-1:0]         rdata,
  output logic [WIN*WIN*DATA_W-1:0] win_data,
  output logic                      win_valid,
  output logic [ROW_W-1:0]          win_row,
  output logic [COL_W-1:0]          win_col,
  output logic                      frame_done,
  output logic                      err_sync
);

  strobe_t s_in;
  strobe_t s_d;

  assign s_in = '{valid: samp_valid, in_range: samp_in_range,
                  line_start: line_start, frame_end: frame_end};

  cfa_strobe_delay #(.RD_LAT(RD_LAT)) u_strobe_delay (
    .clk (clk),
    .rst (rst),
    .d   (s_in),
    .q   (s_d)
  );

  logic [DATA_W-1:0] win     [WIN][WIN];
  logic [DATA_W-1:0] col_reg [WIN-1];
  logic [2:0]        k;
  logic [2:0]        fill;
  logic              first_line;

  logic [2:0]        k_eff;
  logic [2:0]        fill_eff;
  logic [2:0]        fill_nxt;
  logic [DATA_W-1:0] samp;
  logic              col_done;

  // line_start realigns the sample counter and restarts the fill for this sample.
  always_comb begin
    k_eff    = s_d.line_start ? 3'd0 : k;
    fill_eff = s_d.line_start ? 3'd0 : fill;
    fill_nxt = (fill_eff == 3'(WIN)) ? fill_eff : fill_eff + 3'd1;
    samp     = s_d.in_range ? rdata : PAD;
    col_done = s_d.valid && (k_eff == 3'(WIN-1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < WIN; r++)
        for (int c = 0; c < WIN; c++) win[r][c] <= '0;
      for (int r = 0; r < WIN-1; r++) col_reg[r] <= '0;
      k          <= '0;
      fill       <= '0;
      first_line <= 1'b1;
      win_row    <= '0;
      win_col    <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      err_sync   <= 1'b0;
    end else begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (s_d.valid) begin
        if (s_d.line_start) begin
          if (k != 3'd0) err_sync <= 1'b1;
          win_row    <= first_line ? '0 : win_row + 1'b1;
          first_line <= 1'b0;
        end
        if (col_done) begin
          for (int r = 0; r < WIN; r++)
            for (int c = 0; c < WIN-1; c++) win[r][c] <= win[r][c+1];
          for (int r = 0; r < WIN-1; r++) win[r][WIN-1] <= col_reg[r];
          win[WIN-1][WIN-1] <= samp;
          k    <= 3'd0;
          fill <= fill_nxt;
          if (fill_nxt == 3'(WIN)) begin
            win_valid <= 1'b1;
            win_col   <= (fill_eff == 3'(WIN)) ? win_col + 1'b1 : '0;
          end
        end else begin
          col_reg[k_eff[1:0]] <= samp;
          k    <= k_eff + 3'd1;
          fill <= fill_eff;
        end
        // Applied after line_start so a same-sample frame end re-arms first_line.
        if (s_d.frame_end) begin
          if (k_eff != 3'(WIN-1)) err_sync <= 1'b1;
          frame_done <= 1'b1;
          first_line <= 1'b1;
        end
      end
    end
  end

  for (genvar r = 0; r < WIN; r++) begin : g_row
    for (genvar c = 0; c < WIN; c++) begin : g_col
      assign win_data[win_idx(r, c, DATA_W) +: DATA_W] = win[r][c];
    end
  end

endmodule
